// File: rtl/memory_controller.sv
// memory_controller: arbitrates load/store and instruction-fetch requests and
// serializes each access into byte transfers on a byte-wide RAM port.
module memory_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsb_request_in,
  input  logic        lsb_store_in,
  input  logic [1:0]  lsb_size_in,
  input  logic        lsb_signed_in,
  input  logic [31:0] lsb_addr_in,
  input  logic [31:0] lsb_data_in,
  output logic        lsb_done_out,
  output logic [31:0] lsb_data_out,
  input  logic        if_request_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] if_inst_out,
  input  logic        flush_in,
  input  logic [7:0]  mem_din_in,
  output logic [7:0]  mem_dout_out,
  output logic [31:0] mem_a_out,
  output logic        mem_wr_out
);

  typedef enum logic [2:0] {
    IDLE,
    IF_READ,
    LSB_READ,
    LSB_WRITE,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] buf_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [2:0]  step_q;

  logic [2:0]  nbytes;
  logic [2:0]  step_next;
  logic [31:0] assembled;
  logic [31:0] load_ext;
  logic [31:0] wr_shift;

  // Byte count, final-byte merge with the live RAM data, and load extension.
  always_comb begin
    step_next = step_q + 3'd1;
    case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    // The last byte arrives on the same edge the result is registered,
    // so it is merged straight from mem_din_in instead of from buf_q.
    assembled = buf_q;
    case (nbytes)
      3'd1:    assembled[7:0]   = mem_din_in;
      3'd2:    assembled[15:8]  = mem_din_in;
      default: assembled[31:24] = mem_din_in;
    endcase
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{assembled[7]}}, assembled[7:0]}
                                   : {24'h000000, assembled[7:0]};
      2'b01:   load_ext = signed_q ? {{16{assembled[15]}}, assembled[15:0]}
                                   : {16'h0000, assembled[15:0]};
      default: load_ext = assembled;
    endcase
    wr_shift = data_q >> {step_next, 3'b000};
  end

  // Main controller FSM; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      buf_q        <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      step_q       <= '0;
      lsb_done_out <= 1'b0;
      lsb_data_out <= '0;
      if_done_out  <= 1'b0;
      if_inst_out  <= '0;
      mem_dout_out <= '0;
      mem_a_out    <= '0;
      mem_wr_out   <= 1'b0;
    end else begin
      lsb_done_out <= 1'b0;
      if_done_out  <= 1'b0;
      case (state)
        IDLE: begin
          step_q <= '0;
          buf_q  <= '0;
          if (!flush_in) begin
            if (lsb_request_in) begin
              addr_q    <= lsb_addr_in;
              data_q    <= lsb_data_in;
              size_q    <= lsb_size_in;
              signed_q  <= lsb_signed_in;
              mem_a_out <= lsb_addr_in;
              if (lsb_store_in) begin
                mem_wr_out   <= 1'b1;
                mem_dout_out <= lsb_data_in[7:0];
                state        <= LSB_WRITE;
              end else begin
                state <= LSB_READ;
              end
            end else if (if_request_in) begin
              addr_q    <= if_addr_in;
              size_q    <= 2'b10;
              signed_q  <= 1'b0;
              mem_a_out <= if_addr_in;
              state     <= IF_READ;
            end
          end
        end
        IF_READ, LSB_READ: begin
          if (flush_in) begin
            mem_a_out    <= '0;
            mem_wr_out   <= 1'b0;
            mem_dout_out <= '0;
            state        <= IDLE;
          end else begin
            step_q <= step_next;
            // Issue runs one step ahead of capture: at step s the address
            // for byte s+1 goes out while byte s-1 is captured.
            if (step_next < nbytes) mem_a_out <= addr_q + 32'(step_next);
            else                    mem_a_out <= '0;
            case (step_q)
              3'd1:    buf_q[7:0]   <= mem_din_in;
              3'd2:    buf_q[15:8]  <= mem_din_in;
              3'd3:    buf_q[23:16] <= mem_din_in;
              3'd4:    buf_q[31:24] <= mem_din_in;
              default: ;
            endcase
            if (step_q == nbytes) begin
              if (state == IF_READ) begin
                if_inst_out <= assembled;
                if_done_out <= 1'b1;
              end else begin
                lsb_data_out <= load_ext;
                lsb_done_out <= 1'b1;
              end
              state <= DONE;
            end
          end
        end
        LSB_WRITE: begin
          step_q <= step_next;
          if (step_next < nbytes) begin
            mem_a_out    <= addr_q + 32'(step_next);
            mem_dout_out <= wr_shift[7:0];
          end else begin
            mem_a_out    <= '0;
            mem_dout_out <= '0;
            mem_wr_out   <= 1'b0;
            lsb_done_out <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse and RAM write.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsb_request_in = 1'b0;
  logic        lsb_store_in = 1'b0;
  logic [1:0]  lsb_size_in = 2'b00;
  logic        lsb_signed_in = 1'b0;
  logic [31:0] lsb_addr_in = '0;
  logic [31:0] lsb_data_in = '0;
  logic        lsb_done_out;
  logic [31:0] lsb_data_out;
  logic        if_request_in = 1'b0;
  logic [31:0] if_addr_in = '0;
  logic        if_done_out;
  logic [31:0] if_inst_out;
  logic        flush_in = 1'b0;
  logic [7:0]  mem_din_in = '0;
  logic [7:0]  mem_dout_out;
  logic [31:0] mem_a_out;
  logic        mem_wr_out;

  memory_controller dut (
    .clk(clk), .rst(rst),
    .lsb_request_in(lsb_request_in), .lsb_store_in(lsb_store_in),
    .lsb_size_in(lsb_size_in), .lsb_signed_in(lsb_signed_in),
    .lsb_addr_in(lsb_addr_in), .lsb_data_in(lsb_data_in),
    .lsb_done_out(lsb_done_out), .lsb_data_out(lsb_data_out),
    .if_request_in(if_request_in), .if_addr_in(if_addr_in),
    .if_done_out(if_done_out), .if_inst_out(if_inst_out),
    .flush_in(flush_in), .mem_din_in(mem_din_in),
    .mem_dout_out(mem_dout_out), .mem_a_out(mem_a_out), .mem_wr_out(mem_wr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        lsb_q[$];
  exp_t        if_q[$];
  logic [39:0] wr_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  logic [7:0]  ram [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data valid one cycle after the address.
  always @(posedge clk) begin
    if (mem_wr_out) ram[mem_a_out] = mem_dout_out;
    mem_din_in <= ram.exists(mem_a_out) ? ram[mem_a_out] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations on done pulses and RAM writes.
  always @(negedge clk) begin
    exp_t e;
    logic [39:0] w;
    if (lsb_done_out) begin
      if (lsb_q.size() == 0) check("lsb_unexpected_done", 32'd1, 32'd0);
      else begin
        e = lsb_q.pop_front();
        check("lsb_data", lsb_data_out, e.data);
        check("lsb_done_cycle", cyc, e.cyc);
      end
    end
    if (if_done_out) begin
      if (if_q.size() == 0) check("if_unexpected_done", 32'd1, 32'd0);
      else begin
        e = if_q.pop_front();
        check("if_inst", if_inst_out, e.data);
        check("if_done_cycle", cyc, e.cyc);
      end
    end
    if (mem_wr_out) begin
      if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
      else begin
        w = wr_q.pop_front();
        check("write_addr", mem_a_out, w[39:8]);
        check("write_data", {24'h0, mem_dout_out}, {24'h0, w[7:0]});
      end
    end
  end

  function automatic int nb(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Drive an LSB request at a negedge; optionally push the expected result.
  task automatic start_lsb(input logic st, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_data, input logic push);
    exp_t e;
    int lat;
    lsb_request_in = 1'b1;
    lsb_store_in   = st;
    lsb_size_in    = size;
    lsb_signed_in  = sgn;
    lsb_addr_in    = addr;
    lsb_data_in    = data;
    lat = st ? nb(size) : nb(size) + 1;
    e.data = exp_data;
    e.cyc  = cyc + 1 + lat;
    if (push) lsb_q.push_back(e);
  endtask

  task automatic finish_lsb();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (lsb_done_out) seen = 1;
    end
    lsb_request_in = 1'b0;
    lsb_addr_in    = 32'hFFFF_FFFF;
    lsb_data_in    = 32'h5555_5555;
    check("lsb_done_within_bound", {31'h0, seen}, 32'd1);
  endtask

  task automatic start_if(input logic [31:0] addr, input logic [31:0] exp_inst, input int lat);
    exp_t e;
    if_request_in = 1'b1;
    if_addr_in    = addr;
    e.data = exp_inst;
    e.cyc  = cyc + 1 + lat;
    if_q.push_back(e);
  endtask

  task automatic finish_if();
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (if_done_out) seen = 1;
    end
    if_request_in = 1'b0;
    if_addr_in    = 32'hFFFF_FFFF;
    check("if_done_within_bound", {31'h0, seen}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr"},   {31'h0, mem_wr_out}, 32'd0);
    check({tag, "_a"},    mem_a_out, 32'd0);
    check({tag, "_dout"}, {24'h0, mem_dout_out}, 32'd0);
    check({tag, "_lsbdone"}, {31'h0, lsb_done_out}, 32'd0);
    check({tag, "_ifdone"},  {31'h0, if_done_out}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    ram[32'h104] = 8'h93; ram[32'h105] = 8'h02; ram[32'h106] = 8'h10; ram[32'h107] = 8'h00;
    ram[32'h2000] = 8'h80;
    ram[32'h4000] = 8'h78; ram[32'h4001] = 8'h56; ram[32'h4002] = 8'h34; ram[32'h4003] = 8'h12;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_lsb_data", lsb_data_out, 32'd0);
    check("reset_if_inst", if_inst_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word fetch with address sequence check.
    start_if(32'h100, 32'h0010_0513, 5);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fetch_addr", mem_a_out, 32'h100 + 32'(k));
      check("fetch_wr", {31'h0, mem_wr_out}, 32'd0);
    end
    finish_if();
    @(negedge clk);

    // Signed and unsigned byte loads.
    start_lsb(1'b0, 2'b00, 1'b1, 32'h2000, 32'h0, 32'hFFFF_FF80, 1'b1);
    finish_lsb();
    @(negedge clk);
    start_lsb(1'b0, 2'b00, 1'b0, 32'h2000, 32'h0, 32'h0000_0080, 1'b1);
    finish_lsb();
    @(negedge clk);

    // Half store; load result register must hold its last value.
    wr_q.push_back({32'h3001, 8'hEF});
    wr_q.push_back({32'h3002, 8'hBE});
    start_lsb(1'b1, 2'b01, 1'b0, 32'h3001, 32'hDEAD_BEEF, 32'h0000_0080, 1'b1);
    finish_lsb();
    @(negedge clk);

    // Half loads back from the stored location.
    start_lsb(1'b0, 2'b01, 1'b1, 32'h3001, 32'h0, 32'hFFFF_BEEF, 1'b1);
    finish_lsb();
    @(negedge clk);
    start_lsb(1'b0, 2'b01, 1'b0, 32'h3001, 32'h0, 32'h0000_BEEF, 1'b1);
    finish_lsb();
    @(negedge clk);

    // Simultaneous requests: LSB first, IF accepted after the DONE cycle.
    start_if(32'h104, 32'h0010_0293, 12);
    start_lsb(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h1234_5678, 1'b1);
    finish_lsb();
    finish_if();
    @(negedge clk);

    // Flush during the 2nd cycle of a fetch: aborted, no done pulse.
    if_request_in = 1'b1;
    if_addr_in    = 32'h100;
    @(posedge clk);
    @(negedge clk);
    check("flushfetch_addr0", mem_a_out, 32'h100);
    @(negedge clk);
    flush_in = 1'b1;
    if_request_in = 1'b0;
    @(negedge clk);
    flush_in = 1'b0;
    check("flushfetch_wr", {31'h0, mem_wr_out}, 32'd0);
    check("flushfetch_a", mem_a_out, 32'd0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_done_out) dones++;
    end
    check("flushfetch_no_done", dones, 32'd0);
    check("flushfetch_inst_held", if_inst_out, 32'h0010_0293);

    // Flush during a word store is ignored.
    wr_q.push_back({32'h5000, 8'h0D});
    wr_q.push_back({32'h5001, 8'hF0});
    wr_q.push_back({32'h5002, 8'hFE});
    wr_q.push_back({32'h5003, 8'hCA});
    start_lsb(1'b1, 2'b10, 1'b0, 32'h5000, 32'hCAFE_F00D, 32'h1234_5678, 1'b1);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    finish_lsb();
    @(negedge clk);
    start_lsb(1'b0, 2'b00, 1'b1, 32'h5003, 32'h0, 32'hFFFF_FFCA, 1'b1);
    finish_lsb();
    @(negedge clk);

    // Reset in the middle of a word store: two bytes written, no done.
    wr_q.push_back({32'h6000, 8'h44});
    wr_q.push_back({32'h6001, 8'h33});
    start_lsb(1'b1, 2'b10, 1'b0, 32'h6000, 32'h1122_3344, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    lsb_request_in = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    check("midreset_lsb_data", lsb_data_out, 32'd0);
    check("midreset_if_inst", if_inst_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_partial_write", {24'h0, ram[32'h6001]}, 32'h33);
    start_lsb(1'b0, 2'b00, 1'b0, 32'h6001, 32'h0, 32'h0000_0033, 1'b1);
    finish_lsb();
    repeat (4) @(negedge clk);

    check("pending_lsb", lsb_q.size(), 32'd0);
    check("pending_if", if_q.size(), 32'd0);
    check("pending_writes", wr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
# memory_controller

Services memory requests from the load/store buffer (the responder for its load/store requests) and the instruction fetcher. It arbitrates between the two requesters and serializes each access into byte transfers on the single byte-wide RAM port. It returns assembled, sign/zero-extended results with a one-cycle done pulse. It sits between the out-of-order core (load/store buffer, fetcher, reorder-buffer flush) and the external RAM.

## Interface
No parameters. All outputs are registered.
- clk  input  1  system clock
- rst  input  1  reset; synchronous and active-high
- lsb_request_in  input  1  load/store request; held high until lsb_done_out
- lsb_store_in  input  1  0 = load, 1 = store
- lsb_size_in  input  2  00 = byte, 01 = half, 10 = word (11 illegal)
- lsb_signed_in  input  1  sign-extend load result (ignored for word and for stores)
- lsb_addr_in  input  32  byte address
- lsb_data_in  input  32  store data, little-endian, low bytes used
- lsb_done_out  output  1  one-cycle completion pulse
- lsb_data_out  output  32  load result, valid while lsb_done_out is high
- if_request_in  input  1  instruction fetch request; held high until if_done_out
- if_addr_in  input  32  fetch address (4-byte read)
- if_done_out  output  1  one-cycle completion pulse
- if_inst_out  output  32  fetched word, valid while if_done_out is high
- flush_in  input  1  misprediction flush from the reorder buffer
- mem_din_in  input  8  RAM read data; valid one cycle after the address
- mem_dout_out  output  8  RAM write data
- mem_a_out  output  32  RAM byte address
- mem_wr_out  output  1  1 = write, 0 = read

## Operation
- States:
  - IDLE.
  - IF_READ.
  - LSB_READ.
  - LSB_WRITE.
  - DONE: a single cycle in which a done pulse is high and no request is sampled.
- Byte count n: 1 for byte, 2 for half, 4 for word or fetch.
- Arbitration, sampled in IDLE only:
  - If lsb_request_in is high, LSB wins.
  - Otherwise, if if_request_in is high, IF is served.
  - Otherwise, stay in IDLE.
  - IF is never preempted once accepted.
- Address, data and size are latched at acceptance; later changes to the inputs are ignored.
- Reads:
  - Byte k at address addr+k is driven in the k-th busy cycle (k = 0..n-1).
  - Byte k is captured from mem_din_in one cycle later, into bits [8k+7:8k].
- Writes:
  - Byte k of data is driven with mem_wr_out = 1 in the k-th busy cycle.
  - Nothing is sampled back.
- Load result extension:
  - Byte, signed: {24{b[7]}, b[7:0]}. Byte, unsigned: zero-extended.
  - Half, signed: {16{h[15]}, h[15:0]}. Half, unsigned: zero-extended.
  - Word: unchanged.
- Address arithmetic is 32-bit and wraps modulo 2^32. No alignment check is made.
- Flush:
  - flush_in high at an edge while in IF_READ or LSB_READ aborts the access: next state is IDLE, no done pulse, mem_wr_out = 0.
  - flush_in high while in LSB_WRITE is ignored, because stores are already committed. The store completes and pulses lsb_done_out.
  - flush_in high in IDLE blocks acceptance at that edge.
- Outputs while not actively transferring:
  - mem_wr_out = 0, mem_a_out = 0, mem_dout_out = 0.
  - Done outputs are 0.
  - lsb_data_out and if_inst_out hold their last values.
- Reset: all outputs 0, state IDLE. Reset mid-access abandons the access, including a store, with no done pulse.

## Timing
- Request accepted at edge E (IDLE, request high).
  - mem_a_out = addr from the cycle after E.
  - One new byte address per cycle.
- Read of n bytes:
  - The last byte is captured at edge E+n+1.
  - The done pulse is high in the cycle following edge E+n+1: word/fetch E+5, half E+3, byte E+2.
- Write of n bytes:
  - The last byte is driven in the cycle after edge E+n-1.
  - The done pulse is high in the cycle following edge E+n: word E+4, byte E+1.
  - mem_wr_out is high for exactly n consecutive cycles.
- DONE state lasts exactly one cycle. The next acceptance is possible at the edge ending the DONE cycle +1. A requester that drops its request on seeing done is therefore never re-accepted.
- Back-to-back throughput: one access per n+3 cycles for reads and n+2 cycles for writes.

## Test plan
- Word fetch:
  - Stimulus: if_addr_in = 0x100, RAM bytes 0x13,0x05,0x10,0x00.
  - Response: mem_a_out = 0x100..0x103 on consecutive cycles; if_done_out one cycle; if_inst_out = 0x00100513.
- Signed byte load: lsb_addr_in = 0x2000, byte 0x80 → lsb_data_out = 0xFFFFFF80. Same access unsigned → 0x00000080. Done at E+2.
- Half store:
  - Stimulus: addr 0x3001, data 0xDEADBEEF.
  - Response: mem_wr_out high 2 cycles; writes 0xEF→0x3001, 0xBE→0x3002; lsb_done_out at E+2.
- Simultaneous requests:
  - Stimulus: if and lsb (word load) raised in the same cycle.
  - Response: LSB served first; IF accepted after the DONE cycle; each done pulses exactly once.
- Flush:
  - Flush during the 2nd cycle of a word fetch → no if_done_out, mem_wr_out = 0, IDLE next.
  - Flush during a word store → all 4 bytes written and lsb_done_out pulses.
- Reset mid-word-store: mem_wr_out = 0 and all outputs 0 on the next cycle; no done pulse; a new request is accepted normally afterward.
